// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline package: arbiter state encoding and default bus widths
// for the single-port memory arbiter between fetch and data stages.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    IF_DROP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data-memory stages onto one shared
// single-port memory, one transaction outstanding, data before fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t        state_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              dm_we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic dm_active;
  logic dm_elig;
  logic if_elig;
  logic issue_dm;
  logic issue_if;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    dm_active = dm_read | dm_write;
    // An agent whose valid is high is still presenting its retiring access.
    dm_elig   = dm_active & ~dm_valid_q;
    if_elig   = if_req & ~if_valid_q & ~if_flush & ~dm_elig;
    issue_dm  = (state_q == IDLE) & dm_elig;
    issue_if  = (state_q == IDLE) & if_elig;

    // rst_n gating keeps the request low for the whole reset, not just after the edge.
    mem_req   = rst_n & (issue_dm | issue_if);
    mem_we    = issue_dm & dm_write;
    mem_addr  = dm_elig ? dm_addr : if_addr;
    mem_wdata = dm_elig ? dm_wdata : '0;
    mem_wstrb = dm_elig ? dm_wstrb : '0;
  end

  assign stall_mem = dm_active & ~dm_valid_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      dm_we_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((issue_dm | issue_if) && mem_gnt) begin
            if (issue_dm) begin
              state_q <= DM_WAIT;
              dm_we_q <= dm_write;
            end else begin
              state_q <= IF_WAIT;
            end
          end
        end
        IF_WAIT: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            if (!if_flush) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end else if (if_flush) begin
            state_q <= IF_DROP;
          end
        end
        DM_WAIT: begin
          if (mem_rvalid) begin
            state_q    <= IDLE;
            dm_valid_q <= 1'b1;
            dm_rdata_q <= dm_we_q ? '0 : mem_rdata;
          end
        end
        IF_DROP: begin
          if (mem_rvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch stage requests an instruction word.
REQ-006 if_addr  in  ADDR_W  fetch address (PC).
REQ-007 if_flush  in  1  IF_Flush from the hazard unit; cancels the current fetch.
REQ-008 if_rdata / if_valid  out  DATA_W / 1  fetched word, valid one cycle.
REQ-009 dm_read / dm_write  in  1 / 1  MEM-stage load / store request, mutually exclusive.
REQ-010 dm_addr / dm_wdata / dm_wstrb  in  ADDR_W / DATA_W / DATA_W/8  data access fields.
REQ-011 dm_rdata / dm_valid  out  DATA_W / 1  load data / access-complete pulse.
REQ-012 stall_if / stall_mem  out  1 / 1  freeze IF (PCWrite, IF_ID write) / freeze MEM and older stages.
REQ-013 mem_req / mem_we / mem_addr / mem_wdata / mem_wstrb  out  shared single-port memory request.
REQ-014 mem_gnt  in  1  memory accepts the request in the same cycle as mem_req.
REQ-015 mem_rvalid / mem_rdata  in  1 / DATA_W  response, one per accepted request, including writes.

Function
REQ-016 FSM states: IDLE, IF_WAIT, DM_WAIT, IF_DROP; exactly one outstanding memory transaction.
REQ-017 IDLE issue rule: data (dm_read|dm_write) has priority over fetch; fetch issues only when no data access is eligible.
REQ-018 mem_req is combinational in IDLE and held with stable fields until mem_gnt.
REQ-019 Grant of data -> DM_WAIT; grant of fetch -> IF_WAIT; no grant -> stay IDLE and re-arbitrate the next cycle.
REQ-020 mem_we = dm_write for data issues; 0 and mem_wstrb = 0 for fetches.
REQ-021 IF_WAIT with mem_rvalid -> IDLE; the next cycle if_valid = 1 and if_rdata = registered mem_rdata.
REQ-022 DM_WAIT with mem_rvalid -> IDLE; the next cycle dm_valid = 1; dm_rdata is registered mem_rdata for loads and 0 for stores.
REQ-023 Minimum latency is request-to-valid = 2 cycles (grant cycle, rvalid cycle +1); if_valid and dm_valid are single-cycle pulses.
REQ-024 Completion cycle: an agent whose valid is high does not issue in that cycle, since its request still reflects the retiring access; the other agent may issue.
REQ-025 stall_mem = (dm_read|dm_write) & ~dm_valid.
REQ-026 stall_if = (if_req & ~if_valid) | stall_mem.
REQ-027 if_flush in IF_WAIT without mem_rvalid -> IF_DROP; in IF_DROP, mem_rvalid -> IDLE with no if_valid.
REQ-028 if_flush in the IF_WAIT cycle with mem_rvalid: response discarded, no if_valid, -> IDLE.
REQ-029 if_flush in IDLE suppresses fetch issue that cycle; data issue is unaffected.
REQ-030 if_flush has no effect on DM_WAIT or on a pending dm_valid.
REQ-031 mem_rvalid in IDLE is ignored (protocol error, no output change).

Reset
REQ-032 rst_n low: state = IDLE; if_valid, dm_valid = 0; if_rdata, dm_rdata = 0; mem_req = 0 for the duration of reset.
REQ-033 Reset mid-transaction abandons it; the memory is reset by the same rst_n, and no stale response is forwarded.

Structure
REQ-034 arb_state_t enum and the ADDR_W/DATA_W defaults live in the shared pipeline package.
REQ-035 The block is one flat module with no sub-module; FSM, response registers and stall logic are inline.

Verification
REQ-036 Fetch only: if_req=1, if_addr=0x100, mem_gnt=1, rvalid after 3 cycles with rdata=0x00A00093 -> if_valid one cycle carrying 0x00A00093; stall_if high until then.
REQ-037 Simultaneous requests: if_req=1 and dm_read=1 (dm_addr=0x2000) in IDLE -> mem_addr=0x2000 issued first; fetch issued only after dm_valid.
REQ-038 Store: dm_write=1, wdata=0xDEADBEEF, wstrb=0xF -> mem_we=1 with those fields; dm_valid=1 and dm_rdata=0; stall_mem drops on the dm_valid cycle.
REQ-039 Flush in flight: fetch granted, if_flush=1 next cycle, rvalid two cycles later -> no if_valid; state passes through IF_DROP to IDLE.
REQ-040 Back-pressure: mem_gnt=0 for 4 cycles -> mem_req and mem_addr held stable; issue completes on the first mem_gnt=1.
REQ-041 Async reset asserted in DM_WAIT -> mem_req, dm_valid and if_valid = 0 immediately; IDLE after release, then normal operation.
